sequential_multiplicator_dispatcher: RTL and testbench

- Upstream feeder and downstream collector for sequential_multiplicator.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Launches one multiplication at a time: holds operands stable, drives a single-cycle start, then waits for done.
- Captures product/overflow into a one-entry result register with valid/ready output. A watchdog recovers a hung multiplier.

---
 rtl/sequential_multiplicator_dispatcher.sv | 188 ++++++++++++++++++
 tb/tb_sequential_multiplicator_dispatcher.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequential_multiplicator_dispatcher.sv
// Feeds operand pairs from a small FIFO into a sequential multiplier one job at a time,
// collects each product into a one-entry result register and recovers a hung multiplier.
module sequential_multiplicator_dispatcher #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                         clock,
  input  logic                         reset_in,
  input  logic                         op_valid_in,
  output logic                         op_ready_out,
  input  logic [WIDTH-1:0]             multiplicand_in,
  input  logic [WIDTH-1:0]             multiplier_in,
  output logic [WIDTH-1:0]             mul_multiplicand_out,
  output logic [WIDTH-1:0]             mul_multiplier_out,
  output logic                         mul_start_out,
  output logic                         mul_reset_out,
  input  logic                         mul_done_in,
  input  logic [2*WIDTH-1:0]           mul_product_in,
  input  logic                         mul_overflow_in,
  output logic                         res_valid_out,
  input  logic                         res_ready_in,
  output logic [2*WIDTH-1:0]           product_out,
  output logic                         overflow_out,
  output logic                         error_out,
  output logic [$clog2(DEPTH):0]       count_out
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT);
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
  } op_pair_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RECOVER
  } state_t;

  state_t             state_q, state_d;
  op_pair_t           mem [DEPTH];
  op_pair_t           head;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               start_q, start_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               res_valid_q, res_valid_d;
  logic [PROD_W-1:0]  product_q, product_d;
  logic               overflow_q, overflow_d;
  logic               error_q, error_d;
  logic               push_c;
  logic               pop_c;

  assign op_ready_out         = (count_q != CNT_W'(DEPTH));
  assign push_c               = op_valid_in & op_ready_out;
  assign head                 = mem[rd_ptr_q];

  assign count_out            = count_q;
  assign mul_multiplicand_out = mcand_q;
  assign mul_multiplier_out   = mplier_q;
  assign mul_start_out        = start_q;
  assign res_valid_out        = res_valid_q;
  assign product_out          = product_q;
  assign overflow_out         = overflow_q;
  assign error_out            = error_q;

  // Multiplier reset pulses low for the single recovery cycle, and always with system reset.
  assign mul_reset_out        = reset_in & (state_q != S_RECOVER);

  // Operand storage; contents are meaningless outside the occupied window so no reset.
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem[wr_ptr_q] <= op_pair_t'({multiplicand_in, multiplier_in});
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Dispatcher FSM next-state and registered outputs.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    start_d     = 1'b0;
    timer_d     = timer_q;
    res_valid_d = res_valid_q;
    product_d   = product_q;
    overflow_d  = overflow_q;
    error_d     = error_q;
    pop_c       = 1'b0;

    if (res_valid_q && res_ready_in) begin
      res_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        // A pending result blocks the next launch so results cannot be overwritten.
        if ((count_q != '0) && !res_valid_q) begin
          pop_c    = 1'b1;
          mcand_d  = head.multiplicand;
          mplier_d = head.multiplier;
          start_d  = 1'b1;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done_in) begin
          product_d   = mul_product_in;
          overflow_d  = mul_overflow_in;
          res_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_RECOVER;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RECOVER: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      start_q     <= 1'b0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      product_q   <= '0;
      overflow_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      start_q     <= start_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      product_q   <= product_d;
      overflow_q  <= overflow_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_sequential_multiplicator_dispatcher.sv
// Directed bench for sequential_multiplicator_dispatcher with a behavioural multiplier model.
module tb_sequential_multiplicator_dispatcher;

  localparam int W       = 8;
  localparam int D       = 4;
  localparam int TO      = 64;
  localparam int MDL_LAT = 8;

  logic            clock = 1'b0;
  logic            reset_in = 1'b0;
  logic            op_valid = 1'b0;
  logic            op_ready_out;
  logic [W-1:0]    op_a = '0;
  logic [W-1:0]    op_b = '0;
  logic [W-1:0]    mul_multiplicand_out;
  logic [W-1:0]    mul_multiplier_out;
  logic            mul_start_out;
  logic            mul_reset_out;
  logic            res_valid_out;
  logic            res_ready = 1'b0;
  logic [2*W-1:0]  product_out;
  logic            overflow_out;
  logic            error_out;
  logic [$clog2(D):0] count_out;

  // multiplier model state
  logic            mdl_busy = 1'b0;
  int              mdl_cnt = 0;
  logic [2*W-1:0]  mdl_prod = '0;
  logic            mdl_ovf = 1'b0;
  logic            mdl_done = 1'b0;
  bit              mdl_stall = 1'b0;
  bit              mdl_force = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  sequential_multiplicator_dispatcher #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clock                (clock),
    .reset_in             (reset_in),
    .op_valid_in          (op_valid),
    .op_ready_out         (op_ready_out),
    .multiplicand_in      (op_a),
    .multiplier_in        (op_b),
    .mul_multiplicand_out (mul_multiplicand_out),
    .mul_multiplier_out   (mul_multiplier_out),
    .mul_start_out        (mul_start_out),
    .mul_reset_out        (mul_reset_out),
    .mul_done_in          (mdl_done),
    .mul_product_in       (mdl_prod),
    .mul_overflow_in      (mdl_ovf),
    .res_valid_out        (res_valid_out),
    .res_ready_in         (res_ready),
    .product_out          (product_out),
    .overflow_out         (overflow_out),
    .error_out            (error_out),
    .count_out            (count_out)
  );

  always #5 clock = ~clock;

  // Multiplier model: latches operands on start, pulses done MDL_LAT cycles later.
  always @(posedge clock) begin
    mdl_done <= 1'b0;
    if (!mul_reset_out) begin
      mdl_busy <= 1'b0;
      mdl_cnt  <= 0;
    end else if (mul_start_out && !mdl_busy) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= 0;
      mdl_prod <= mdl_force ? 16'hFF01 : 16'(mul_multiplicand_out) * 16'(mul_multiplier_out);
      mdl_ovf  <= mdl_force;
    end else if (mdl_busy && !mdl_stall) begin
      if (mdl_cnt == MDL_LAT - 1) begin
        mdl_done <= 1'b1;
        mdl_busy <= 1'b0;
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    bit             frc;
    logic [2*W-1:0] prod;
    logic           ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clock);
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    while (!op_ready_out && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!op_ready_out) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got not-ready expected ready for %0d x %0d", a, b);
    end
    @(posedge clock);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [2*W-1:0] ep, input logic eo, input string name, input bit accept);
    int n = 0;
    @(negedge clock);
    while (!res_valid_out && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!res_valid_out) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no result expected product %0h", name, ep);
      return;
    end
    check({name, "_prod"}, 32'(product_out), 32'(ep));
    check({name, "_ovf"}, 32'(overflow_out), 32'(eo));
    if (accept) begin
      res_ready = 1'b1;
      @(negedge clock);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s_cnt, s_idx, v_cnt, v_idx, lows, first_low, bad, starts;
    logic [2*W-1:0] v_prod;
    logic v_ovf;
    logic [W-1:0] s_a, s_b;
    logic err_before, err_after;

    vecs[0] = '{8'd12,  8'd13,  1'b0, 16'd156,  1'b0};
    vecs[1] = '{8'd255, 8'd255, 1'b1, 16'hFF01, 1'b1};
    vecs[2] = '{8'd0,   8'd200, 1'b0, 16'd0,    1'b0};
    vecs[3] = '{8'd1,   8'd1,   1'b0, 16'd1,    1'b0};
    vecs[4] = '{8'd200, 8'd3,   1'b0, 16'd600,  1'b0};
    vecs[5] = '{8'd255, 8'd1,   1'b0, 16'd255,  1'b0};

    // reset state
    repeat (3) @(negedge clock);
    check("rst_count", 32'(count_out), 0);
    check("rst_ready", 32'(op_ready_out), 1);
    check("rst_start", 32'(mul_start_out), 0);
    check("rst_mcand", 32'(mul_multiplicand_out), 0);
    check("rst_mplier", 32'(mul_multiplier_out), 0);
    check("rst_mulrst", 32'(mul_reset_out), 0);
    check("rst_valid", 32'(res_valid_out), 0);
    check("rst_prod", 32'(product_out), 0);
    check("rst_ovf", 32'(overflow_out), 0);
    check("rst_err", 32'(error_out), 0);
    reset_in = 1'b1;
    #1 check("rel_mulrst", 32'(mul_reset_out), 1);

    // single job latency: 12 x 13
    res_ready = 1'b1;
    push(8'd12, 8'd13);
    s_cnt = 0; s_idx = -1; v_cnt = 0; v_idx = -1; v_prod = '0; v_ovf = 1'b1; s_a = '0; s_b = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mul_start_out) begin
        s_cnt++;
        if (s_idx < 0) begin
          s_idx = i; s_a = mul_multiplicand_out; s_b = mul_multiplier_out;
        end
      end
      if (res_valid_out) begin
        v_cnt++;
        if (v_idx < 0) begin
          v_idx = i; v_prod = product_out; v_ovf = overflow_out;
        end
      end
    end
    check("lat_start_cycles", 32'(s_cnt), 1);
    check("lat_start_idx", 32'(s_idx), 1);
    check("lat_start_a", 32'(s_a), 12);
    check("lat_start_b", 32'(s_b), 13);
    check("lat_valid_idx", 32'(v_idx), 11);
    check("lat_valid_cycles", 32'(v_cnt), 1);
    check("lat_prod", 32'(v_prod), 156);
    check("lat_ovf", 32'(v_ovf), 0);

    // table of single jobs incl. overflow passthrough
    for (int i = 0; i < 6; i++) begin
      mdl_force = vecs[i].frc;
      push(vecs[i].a, vecs[i].b);
      wait_result(vecs[i].prod, vecs[i].ovf, $sformatf("vec%0d", i), 1'b1);
    end
    mdl_force = 1'b0;

    // burst/full: a pending result blocks dispatch while the FIFO fills
    res_ready = 1'b0;
    push(8'd0, 8'd5);
    wait_result(16'd0, 1'b0, "prime", 1'b0);
    push(8'd1, 8'd2);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    push(8'd7, 8'd8);
    @(negedge clock);
    check("full_count", 32'(count_out), 4);
    check("full_ready", 32'(op_ready_out), 0);
    fork
      push(8'd9, 8'd10);
      begin
        repeat (3) @(negedge clock);
        check("full_held_count", 32'(count_out), 4);
        res_ready = 1'b1;
      end
    join
    wait_result(16'd2,  1'b0, "burst0", 1'b1);
    wait_result(16'd12, 1'b0, "burst1", 1'b1);
    wait_result(16'd30, 1'b0, "burst2", 1'b1);
    wait_result(16'd56, 1'b0, "burst3", 1'b1);
    wait_result(16'd90, 1'b0, "burst4", 1'b1);

    // backpressure: first result held, no second launch
    res_ready = 1'b0;
    push(8'd11, 8'd2);
    push(8'd4, 8'd4);
    wait_result(16'd22, 1'b0, "bp_first", 1'b0);
    bad = 0; starts = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!res_valid_out || product_out != 16'd22) bad++;
      if (mul_start_out) starts++;
    end
    check("bp_stable", 32'(bad), 0);
    check("bp_no_start", 32'(starts), 0);
    check("bp_count", 32'(count_out), 1);
    wait_result(16'd22, 1'b0, "bp_accept", 1'b1);
    check("bp_start_not_yet", 32'(mul_start_out), 0);
    @(negedge clock);
    check("bp_start_next", 32'(mul_start_out), 1);
    wait_result(16'd16, 1'b0, "bp_second", 1'b1);

    // timeout: first job hangs, next job completes
    mdl_stall = 1'b1;
    push(8'd7, 8'd7);
    push(8'd3, 8'd3);
    lows = 0; first_low = -1; v_cnt = 0; err_before = 1'b1; err_after = 1'b0;
    for (int i = 1; i <= 72; i++) begin
      @(negedge clock);
      if (!mul_reset_out) begin
        lows++;
        if (first_low < 0) first_low = i;
        mdl_stall = 1'b0;
      end
      if (res_valid_out) v_cnt++;
      if (i == 65) err_before = error_out;
      if (i == 72) err_after = error_out;
    end
    mdl_stall = 1'b0;
    check("to_reset_idx", 32'(first_low), 66);
    check("to_reset_cycles", 32'(lows), 1);
    check("to_err_before", 32'(err_before), 0);
    check("to_err_after", 32'(err_after), 1);
    check("to_no_result", 32'(v_cnt), 0);
    wait_result(16'd9, 1'b0, "to_next", 1'b1);
    check("to_err_sticky", 32'(error_out), 1);

    // reset mid-WAIT with 3 queued jobs
    mdl_stall = 1'b1;
    push(8'd1, 8'd1);
    push(8'd2, 8'd2);
    push(8'd3, 8'd3);
    push(8'd4, 8'd4);
    repeat (5) @(negedge clock);
    check("mid_count_pre", 32'(count_out), 3);
    reset_in = 1'b0;
    #1;
    check("mid_count", 32'(count_out), 0);
    check("mid_ready", 32'(op_ready_out), 1);
    check("mid_start", 32'(mul_start_out), 0);
    check("mid_mcand", 32'(mul_multiplicand_out), 0);
    check("mid_mulrst", 32'(mul_reset_out), 0);
    check("mid_valid", 32'(res_valid_out), 0);
    check("mid_prod", 32'(product_out), 0);
    check("mid_err", 32'(error_out), 0);
    @(negedge clock);
    reset_in = 1'b1;
    mdl_stall = 1'b0;
    v_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (res_valid_out) v_cnt++;
    end
    check("mid_no_result", 32'(v_cnt), 0);
    check("mid_count_post", 32'(count_out), 0);
    push(8'd6, 8'd7);
    wait_result(16'd42, 1'b0, "post_reset", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
